// File: rtl/uart_pkg.sv
// Shared UART definitions: default timing, frame geometry and framer state encoding.
// Used by both the transmit path and the receiver side.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LEVEL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained by a serial framer onto a registered tx line.
// Back-to-back frames reload straight from STOP into START with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LEVEL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  output logic               tx,
  output logic               busy,
  output logic [LEVEL_W-1:0] fifo_level
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             pop;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             terminal;

  sync_fifo #(
    .WIDTH   (8),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign wr_ready = !full;
  assign busy     = (state != IDLE) || (fifo_level != '0);
  assign terminal = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // tx is computed one edge ahead so the line itself comes straight from a flop.
  always_comb begin
    state_n   = state;
    cnt_n     = terminal ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (terminal) begin
          tx_n      = shift[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (terminal) begin
          if (bit_idx != BIT_LAST) begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 1'b1;
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (terminal) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=16.
// Accepted writes queue expected bytes; a serial receiver model pops and compares each frame.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_level;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  sb[$];

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16),
    .LEVEL_W      (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    if (wr_ready) sb.push_back(b);
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    while (busy && n < bound) begin
      cycle();
      n++;
    end
    if (busy) check("drain_timeout", 32'(busy), 32'd0);
  endtask

  // Receiver model: samples each bit mid-cell on the falling clock edge.
  bit          mon_active = 1'b0;
  int unsigned mon_cnt = 0;
  logic [7:0]  mon_byte = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) check("start_bit", 32'(tx), 32'd0);
        if (mon_cnt % 4 == 2 && mon_cnt / 4 >= 1 && mon_cnt / 4 <= 8)
          mon_byte[mon_cnt/4-1] = tx;
        if (mon_cnt == 38) begin
          check("stop_bit", 32'(tx), 32'd1);
          if (sb.size() == 0) check("unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
          else check("rx_byte", 32'(mon_byte), 32'(sb.pop_front()));
        end
        if (mon_cnt == 39) mon_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [9:0] frame_a5;
    int unsigned n, peak, acc, acc41, low_tx;
    logic [7:0] d;
    logic exp_rdy;

    // Reset values
    cycle(); cycle();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;
    cycle();

    // Single 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop
    frame_a5 = 10'b1_1010_0101_0;
    write_byte(8'hA5);
    check("a5_latency_tx", 32'(tx), 32'd1);
    for (int i = 0; i < 40; i++) begin
      cycle();
      check("a5_tx_bit", 32'(tx), 32'(frame_a5[i/4]));
    end
    check("a5_busy_last", 32'(busy), 32'd1);
    cycle();
    check("a5_busy_fall", 32'(busy), 32'd0);

    // Three back-to-back bytes
    cycle();
    write_byte(8'h01);
    peak = fifo_level;
    write_byte(8'h80);
    if (fifo_level > peak) peak = fifo_level;
    write_byte(8'hFF);
    if (fifo_level > peak) peak = fifo_level;
    n = 0;
    while (busy && n < 300) begin
      cycle();
      n++;
      if (fifo_level > peak) peak = fifo_level;
    end
    check("burst_level_peak", 32'(peak), 32'd2);
    check("burst_busy_cycles", n, 32'd119);

    // Hold wr_valid: 17 accepted before the first stop ends, then exactly one more
    cycle();
    d = 8'h10; acc = 0; acc41 = 0;
    wr_valid = 1'b1;
    for (int j = 0; j <= 60; j++) begin
      exp_rdy = (j <= 16) || (j == 42);
      check("hold_ready", 32'(wr_ready), 32'(exp_rdy));
      if (wr_ready) begin
        wr_data = d;
        sb.push_back(d);
        acc++;
      end else begin
        wr_data = 8'hEE;
      end
      cycle();
      if (wr_ready === 1'b0 || j != 60) begin end
      if (acc == 18 && wr_data == d) d++;
      else if (acc <= 17 && wr_data == d) d++;
      if (j == 41) acc41 = acc;
    end
    wr_valid = 1'b0;
    check("hold_accepted_17", acc41, 32'd17);
    check("hold_accepted_total", acc, 32'd18);
    wait_idle(2000);

    // Reset during DATA bit 3 of 0x3C with 5 bytes queued
    cycle();
    write_byte(8'h3C);
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    write_byte(8'h44); write_byte(8'h55);
    for (int i = 0; i < 12; i++) cycle();
    check("mid_level", 32'(fifo_level), 32'd5);
    check("mid_tx_bit3", 32'(tx), 32'd1);
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h99;
    sb.delete();
    cycle();
    rst = 1'b0;
    wr_valid = 1'b0;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    low_tx = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (tx !== 1'b1 || busy !== 1'b0) low_tx++;
    end
    check("post_rst_silent", low_tx, 32'd0);

    // Simultaneous push and pop at level 3
    write_byte(8'hA1); write_byte(8'hB2); write_byte(8'hC3); write_byte(8'hD4);
    for (int i = 0; i < 37; i++) cycle();
    check("pp_level_before", 32'(fifo_level), 32'd3);
    write_byte(8'hE5);
    check("pp_level_after", 32'(fifo_level), 32'd3);
    check("pp_next_start", 32'(tx), 32'd0);
    wait_idle(1000);

    cycle(); cycle();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
